// File: rtl/counter_arb.sv
// counter_arb: round-robin arbiter in front of a shared up/down counter.
//
// Each cycle at most one requester is granted. The grant scan starts at the
// round-robin pointer. A granted requester bumps the shared counter up
// (dir=1) or down (dir=0).
//
// A three-state FSM (IDLE / ACTIVE / CLEAR) tracks activity. A synchronous
// clr forces CLEAR, which zeroes the counter and the pointer.
//
// Optional feature: define COUNTER_ARB_SAT_EN to saturate the counter at
// 0 and MAX_VAL, with a one-cycle sat pulse when a transfer is clipped.
// Without it, the counter wraps modulo 2^CNT_W and sat is tied low.
//
// Parameters:
//   N_REQ   number of requesters (2..8)
//   CNT_W   counter width
//   MAX_VAL upper saturation bound (saturation builds only)
// Ports:
//   clk     clock, rising edge
//   rst_n   asynchronous active-low reset
//   clr     synchronous clear request, highest priority
//   req     per-requester request, held until granted
//   dir     per-requester direction (1 = increment, 0 = decrement)
//   gnt     one-hot grant, combinational
//   cnt     registered counter value
//   last_id registered index of the most recently granted requester
//   busy    registered, high while the FSM is ACTIVE
//   sat     registered one-cycle pulse on a clipped transfer
module counter_arb #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned MAX_VAL = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         dir,
  output logic [N_REQ-1:0]         gnt,
  output logic [CNT_W-1:0]         cnt,
  output logic [$clog2(N_REQ)-1:0] last_id,
  output logic                     busy,
  output logic                     sat
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  typedef enum logic [1:0] {StIdle, StActive, StClear} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic [IdxW-1:0]  last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic             win_any;
  logic [IdxW-1:0]  win_idx;
  logic             gnt_en;
  logic             xfer;

  // Index (base + off) mod N_REQ, for off < N_REQ.
  function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] base,
                                             input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[IdxW-1:0];
  endfunction

  // Round-robin scan: first requester at or after ptr_q, wrapping around.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_any && req[rr_idx(ptr_q, i)]) begin
        win_any = 1'b1;
        win_idx = rr_idx(ptr_q, i);
      end
    end
  end

  // Grants are suppressed during reset, on clr, and for the CLEAR cycle.
  assign gnt_en = rst_n && !clr && (state_q != StClear);
  assign xfer   = gnt_en && win_any;
  assign gnt    = xfer ? (N_REQ'(1) << win_idx) : '0;

`ifdef COUNTER_ARB_SAT_EN
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_VAL);
  logic sat_q, sat_d;
`else
  // MAX_VAL only matters when saturation is compiled in.
  logic unused_max_val;
  assign unused_max_val = ^MAX_VAL;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
`ifdef COUNTER_ARB_SAT_EN
    sat_d   = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (clr)       state_d = StClear;
        else if (|req) state_d = StActive;
      end
      StActive: begin
        if (clr)       state_d = StClear;
        else if (~|req) state_d = StIdle;
      end
      // CLEAR lasts exactly one cycle; a held clr re-enters from IDLE.
      StClear: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (clr) begin
      cnt_d = '0;
      ptr_d = '0;
    end else if (xfer) begin
      last_d = win_idx;
      ptr_d  = (win_idx == IdxW'(N_REQ - 1)) ? '0 : win_idx + IdxW'(1);
`ifdef COUNTER_ARB_SAT_EN
      if (dir[win_idx]) begin
        if (cnt_q == MaxCnt) sat_d = 1'b1;
        else                 cnt_d = cnt_q + CNT_W'(1);
      end else begin
        if (cnt_q == '0)     sat_d = 1'b1;
        else                 cnt_d = cnt_q - CNT_W'(1);
      end
`else
      if (dir[win_idx]) cnt_d = cnt_q + CNT_W'(1);
      else              cnt_d = cnt_q - CNT_W'(1);
`endif
    end

    busy_d = (state_d == StActive);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      last_q  <= '0;
      busy_q  <= 1'b0;
`ifdef COUNTER_ARB_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
`ifdef COUNTER_ARB_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign cnt     = cnt_q;
  assign last_id = last_q;
  assign busy    = busy_q;
`ifdef COUNTER_ARB_SAT_EN
  assign sat     = sat_q;
`else
  assign sat     = 1'b0;
`endif

endmodule

// File: tb/tb_counter_arb.sv
// Bench for counter_arb (N_REQ=4, CNT_W=8, MAX_VAL=255). A behavioural model
// of the arbiter and counter is checked against the DUT on every falling
// clock edge. Directed steps also carry hand-computed grant and counter values.
module tb_counter_arb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] req = 4'b1111;
  logic [3:0] dir = 4'b0000;
  logic [3:0] gnt;
  logic [7:0] cnt;
  logic [1:0] last_id;
  logic       busy;
  logic       sat;

  int total = 0;
  int bad   = 0;

  counter_arb #(
    .N_REQ  (4),
    .CNT_W  (8),
    .MAX_VAL(255)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .req    (req),
    .dir    (dir),
    .gnt    (gnt),
    .cnt    (cnt),
    .last_id(last_id),
    .busy   (busy),
    .sat    (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state. States: 0 idle, 1 active, 2 clear.
  int m_cnt = 0;
  int m_ptr = 0;
  int m_last = 0;
  int m_state = 0;
  bit m_sat = 1'b0;

  function automatic int exp_idx();
    if (!rst_n || clr || m_state == 2 || req == 4'b0000) return -1;
    for (int o = 0; o < 4; o++) begin
      if (req[(m_ptr + o) % 4]) return (m_ptr + o) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_gnt();
    int k;
    k = exp_idx();
    if (k < 0) return 4'b0000;
    return 4'(1 << k);
  endfunction

  task automatic model_step();
    int k;
    if (!rst_n) begin
      m_cnt = 0; m_ptr = 0; m_last = 0; m_state = 0; m_sat = 1'b0;
      return;
    end
    k = exp_idx();
    m_sat = 1'b0;
    if (m_state == 2)       m_state = 0;
    else if (clr)           m_state = 2;
    else if (req != 4'b0)   m_state = 1;
    else                    m_state = 0;
    if (clr) begin
      m_cnt = 0;
      m_ptr = 0;
    end else if (k >= 0) begin
      m_last = k;
      m_ptr  = (k + 1) % 4;
`ifdef COUNTER_ARB_SAT_EN
      if (dir[k] && m_cnt == 255)      m_sat = 1'b1;
      else if (!dir[k] && m_cnt == 0)  m_sat = 1'b1;
      else if (dir[k])                 m_cnt = m_cnt + 1;
      else                             m_cnt = m_cnt - 1;
`else
      m_cnt = dir[k] ? (m_cnt + 1) % 256 : (m_cnt + 255) % 256;
`endif
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Compare process: outputs are stable mid-cycle.
  initial forever begin
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(exp_gnt()));
    chk("cnt", 32'(cnt), 32'(m_cnt));
    chk("last_id", 32'(last_id), 32'(m_last));
    chk("busy", 32'(busy), 32'(m_state == 1));
    chk("sat", 32'(sat), 32'(m_sat));
  end

  // Drive one cycle of inputs, check the hand-computed grant, then cross the edge.
  task automatic step(input logic [3:0] r, input logic [3:0] d, input logic c,
                      input logic [3:0] g);
    req = r; dir = d; clr = c;
    #1;
    chk("step_gnt", 32'(gnt), 32'(g));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with requests pending: no grant, all registers zero.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;

    // Full rotation, all increments.
    step(4'b1111, 4'b1111, 1'b0, 4'b0001);
    step(4'b1111, 4'b1111, 1'b0, 4'b0010);
    step(4'b1111, 4'b1111, 1'b0, 4'b0100);
    step(4'b1111, 4'b1111, 1'b0, 4'b1000);
    chk("rot_cnt", 32'(cnt), 32'd4);
    chk("rot_last", 32'(last_id), 32'd3);
    chk("rot_busy", 32'(busy), 32'd1);

    // Move ptr to 2, then req=0011 must wrap to 0, then 1.
    step(4'b0010, 4'b1111, 1'b0, 4'b0010);
    step(4'b0011, 4'b1111, 1'b0, 4'b0001);
    step(4'b0011, 4'b1111, 1'b0, 4'b0010);
    chk("wrap_cnt", 32'(cnt), 32'd7);
    // Decrement, then mixed directions.
    step(4'b0100, 4'b0000, 1'b0, 4'b0100);
    step(4'b1001, 4'b0001, 1'b0, 4'b1000);
    step(4'b0001, 4'b0001, 1'b0, 4'b0001);
    chk("mix_cnt", 32'(cnt), 32'd6);
    chk("mix_last", 32'(last_id), 32'd0);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000);
    chk("idle_busy", 32'(busy), 32'd0);

    // Bring cnt to 10, then clear.
    step(4'b0010, 4'b0010, 1'b0, 4'b0010);
    step(4'b0100, 4'b0100, 1'b0, 4'b0100);
    step(4'b1000, 4'b1000, 1'b0, 4'b1000);
    step(4'b0010, 4'b0010, 1'b0, 4'b0010);
    chk("pre_clr_cnt", 32'(cnt), 32'd10);
    step(4'b0001, 4'b0001, 1'b1, 4'b0000);
    chk("clr_cnt", 32'(cnt), 32'd0);
    chk("clr_last_hold", 32'(last_id), 32'd1);
    chk("clr_busy", 32'(busy), 32'd0);
    step(4'b0001, 4'b0001, 1'b0, 4'b0000);

    // Held clr alternates CLEAR / IDLE.
    step(4'b0000, 4'b0000, 1'b1, 4'b0000);
    step(4'b0001, 4'b0001, 1'b1, 4'b0000);
    step(4'b0001, 4'b0001, 1'b0, 4'b0001);
    step(4'b0000, 4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 4'b0000, 1'b1, 4'b0000);
    step(4'b0001, 4'b0001, 1'b0, 4'b0000);

    // Bounds: decrement at 0, then increment.
    step(4'b0001, 4'b0000, 1'b0, 4'b0001);
`ifdef COUNTER_ARB_SAT_EN
    chk("dec0_cnt", 32'(cnt), 32'd0);
    chk("dec0_sat", 32'(sat), 32'd1);
`else
    chk("dec0_cnt", 32'(cnt), 32'd255);
    chk("dec0_sat", 32'(sat), 32'd0);
`endif
    step(4'b0010, 4'b0010, 1'b0, 4'b0010);
`ifdef COUNTER_ARB_SAT_EN
    chk("inc_cnt", 32'(cnt), 32'd1);
`else
    chk("inc255_cnt", 32'(cnt), 32'd0);
`endif
    chk("inc_sat", 32'(sat), 32'd0);

    // Stream to cnt=7, then reset mid-cycle.
    step(4'b0000, 4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000);
    for (int i = 0; i < 7; i++) step(4'b1111, 4'b1111, 1'b0, 4'(1 << (i % 4)));
    chk("stream_cnt", 32'(cnt), 32'd7);
    req = 4'b1111; dir = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(cnt), 32'd0);
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(4'b1111, 4'b1111, 1'b0, 4'b0001);
    chk("post_rst_last", 32'(last_id), 32'd0);
    chk("post_rst_cnt", 32'(cnt), 32'd1);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
